// File: rtl/aig_truth_table_scanner.sv
// Exhaustive truth-table scanner for one combinational AIG with N_IN inputs.
// On an accepted start it drives every input vector in ascending order, waits
// SETTLE cycles per vector, samples z, and checks it against a captured table.
// Optional feature macro: AIG_SCAN_EARLY_EXIT_EN (stop at the first mismatch).
module aig_truth_table_scanner #(
   parameter int unsigned N_IN   = 3,
   parameter int unsigned SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [(1<<N_IN)-1:0]  expected,
   output logic [N_IN-1:0]       dut_x,
   input  logic                  dut_z,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [(1<<N_IN)-1:0]  tt,
   output logic [N_IN:0]         mismatch_cnt,
   output logic [N_IN-1:0]       first_fail_idx,
   output logic                  first_fail_valid
);

   localparam int unsigned TT_W  = 1 << N_IN;
   localparam int unsigned CNT_W = N_IN + 1;
   localparam int unsigned WAIT_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q;
   state_t              state_d;
   logic [N_IN-1:0]     idx_q;
   logic [WAIT_W-1:0]   wait_q;
   logic [TT_W-1:0]     exp_q;

   logic                sample_c;
   logic                last_c;
   logic                miss_c;
   logic                exit_c;
   logic [CNT_W-1:0]    cnt_next_c;

   // Sample edge: current vector has settled for SETTLE cycles
   assign sample_c = (state_q == RUN) && (wait_q == WAIT_W'(SETTLE));
   assign last_c   = (idx_q == N_IN'(TT_W - 1));
   assign miss_c   = (dut_z != exp_q[idx_q]);

`ifdef AIG_SCAN_EARLY_EXIT_EN
   // Scan ends on the last vector or on the first mismatch
   assign exit_c = last_c || miss_c;
`else
   // Scan always covers every vector
   assign exit_c = last_c;
`endif

   // Mismatch count after this sample, saturating at TT_W
   assign cnt_next_c = (miss_c && (mismatch_cnt != CNT_W'(TT_W)))
                       ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (sample_c && exit_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs, counters and captured expected table
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q            <= '0;
         wait_q           <= '0;
         exp_q            <= '0;
         dut_x            <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         tt               <= '0;
         mismatch_cnt     <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  exp_q            <= expected;
                  tt               <= '0;
                  mismatch_cnt     <= '0;
                  first_fail_idx   <= '0;
                  first_fail_valid <= 1'b0;
                  pass             <= 1'b0;
                  idx_q            <= '0;
                  wait_q           <= '0;
                  dut_x            <= '0;
                  busy             <= 1'b1;
               end
            end
            RUN: begin
               if (!sample_c) begin
                  wait_q <= wait_q + WAIT_W'(1);
               end else begin
                  tt[idx_q]    <= dut_z;
                  mismatch_cnt <= cnt_next_c;
                  if (miss_c && !first_fail_valid) begin
                     first_fail_idx   <= idx_q;
                     first_fail_valid <= 1'b1;
                  end
                  wait_q <= '0;
                  if (exit_c) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (cnt_next_c == '0);
                     dut_x <= '0;
                  end else begin
                     idx_q <= idx_q + N_IN'(1);
                     dut_x <= idx_q + N_IN'(1);
                  end
               end
            end
            DONE: begin
               done <= 1'b0;
            end
            default: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
